// File: rtl/unified_mem_arbiter_if.sv
// CPU-side fetch/data ports and SRAM port of the unified memory arbiter.
// slave is the arbiter's view; master is the CPU plus SRAM side.
interface unified_mem_arbiter_if #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int StrbWidth = 4,
  parameter int CntWidth  = 32
);
  logic                 if_req;
  logic [AddrWidth-1:0] if_addr;
  logic [DataWidth-1:0] if_rdata;
  logic                 if_valid;

  logic                 dm_read;
  logic [StrbWidth-1:0] dm_write;
  logic [AddrWidth-1:0] dm_addr;
  logic [DataWidth-1:0] dm_wdata;
  logic [DataWidth-1:0] dm_rdata;
  logic                 dm_valid;

  logic [AddrWidth-1:0] mem_addr;
  logic                 mem_read;
  logic [StrbWidth-1:0] mem_write;
  logic [DataWidth-1:0] mem_wdata;
  logic [DataWidth-1:0] mem_rdata;

  logic                 cpu_stall;
  logic [CntWidth-1:0]  stall_cycles;

  modport slave (
    input  if_req, if_addr,
    input  dm_read, dm_write, dm_addr, dm_wdata,
    input  mem_rdata,
    output if_rdata, if_valid,
    output dm_rdata, dm_valid,
    output mem_addr, mem_read, mem_write, mem_wdata,
    output cpu_stall, stall_cycles
  );

  modport master (
    output if_req, if_addr,
    output dm_read, dm_write, dm_addr, dm_wdata,
    output mem_rdata,
    input  if_rdata, if_valid,
    input  dm_rdata, dm_valid,
    input  mem_addr, mem_read, mem_write, mem_wdata,
    input  cpu_stall, stall_cycles
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port SRAM between instruction fetch and data access.
// Round-robin grant, one access in flight, stall and stall-cycle counter.
module unified_mem_arbiter #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int StrbWidth = 4,
  parameter int CntWidth  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  unified_mem_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    IF_ACC,
    DM_ACC,
    IF_RSP,
    DM_RSP
  } state_t;

  state_t               state;
  logic                 last_dm;
  logic [AddrWidth-1:0] hold_addr;
  logic [DataWidth-1:0] hold_wdata;
  logic [StrbWidth-1:0] hold_strb;
  logic                 mem_read_q;
  logic [StrbWidth-1:0] mem_write_q;
  logic                 if_valid_q;
  logic                 dm_valid_q;
  logic [DataWidth-1:0] if_rdata_q;
  logic [DataWidth-1:0] dm_rdata_q;
  logic [CntWidth-1:0]  stall_q;

  logic dm_pend;
  logic grant_dm;
  logic grant_if;
  logic stall;

  assign dm_pend  = bus.dm_read | (|bus.dm_write);
  // DM wins unless IF is also waiting and DM had the last turn
  assign grant_dm = dm_pend & (~bus.if_req | ~last_dm);
  assign grant_if = bus.if_req & ~grant_dm;

  assign stall = (bus.if_req & ~if_valid_q)
               | (dm_pend & ~dm_valid_q);

  // Serialising FSM: latch request, drive SRAM for one cycle, respond
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_dm     <= 1'b0;
      hold_addr   <= '0;
      hold_wdata  <= '0;
      hold_strb   <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      mem_read_q  <= 1'b0;
      mem_write_q <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_dm) begin
            state       <= DM_ACC;
            last_dm     <= 1'b1;
            hold_addr   <= bus.dm_addr;
            hold_wdata  <= bus.dm_wdata;
            hold_strb   <= bus.dm_write;
            mem_read_q  <= ~(|bus.dm_write);
            mem_write_q <= bus.dm_write;
          end else if (grant_if) begin
            state      <= IF_ACC;
            last_dm    <= 1'b0;
            hold_addr  <= bus.if_addr;
            hold_strb  <= '0;
            mem_read_q <= 1'b1;
          end
        end
        IF_ACC: begin
          state      <= IF_RSP;
          if_valid_q <= 1'b1;
        end
        DM_ACC: begin
          state      <= DM_RSP;
          dm_valid_q <= 1'b1;
        end
        IF_RSP: begin
          state      <= IDLE;
          if_rdata_q <= bus.mem_rdata;
        end
        DM_RSP: begin
          state <= IDLE;
          if (~(|hold_strb)) dm_rdata_q <= bus.mem_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (stall && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  // SRAM data arrives in the response cycle; pass it through then hold it
  assign bus.if_rdata = if_valid_q ? bus.mem_rdata : if_rdata_q;
  assign bus.dm_rdata = (dm_valid_q && ~(|hold_strb))
                      ? bus.mem_rdata : dm_rdata_q;

  assign bus.if_valid     = if_valid_q;
  assign bus.dm_valid     = dm_valid_q;
  assign bus.mem_addr     = hold_addr;
  assign bus.mem_wdata    = hold_wdata;
  assign bus.mem_read     = mem_read_q;
  assign bus.mem_write    = mem_write_q;
  assign bus.cpu_stall    = stall;
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed cases plus random traffic
// checked against a transaction-level schedule and memory model.
module tb_unified_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = '1;

  logic clk = 1'b0;
  logic rst;

  unified_mem_arbiter_if #(
    .AddrWidth(AW), .DataWidth(DW),
    .StrbWidth(SW), .CntWidth(CW)
  ) bus ();

  unified_mem_arbiter #(
    .AddrWidth(AW), .DataWidth(DW),
    .StrbWidth(SW), .CntWidth(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_word(logic [AW-1:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old,
                                          logic [DW-1:0] nw,
                                          logic [SW-1:0] s);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < SW; b++)
      if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // SRAM: registered read, byte-enabled write
  logic [DW-1:0] sram [logic [AW-1:0]];

  function automatic logic [DW-1:0] sram_rd(logic [AW-1:0] a);
    return sram.exists(a) ? sram[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    if (bus.mem_read) bus.mem_rdata <= sram_rd(bus.mem_addr);
    if (bus.mem_write != '0)
      sram[bus.mem_addr] = merge(sram_rd(bus.mem_addr),
                                 bus.mem_wdata, bus.mem_write);
  end

  // Reference memory
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] ref_rd(logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.dm_read  = 1'b0;
    bus.dm_write = '0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Transaction-level reference state
  int            next_free;
  bit            lg_dm;
  int            if_rsp_at, dm_rsp_at, acc_at;
  logic [DW-1:0] e_ifr, e_dmr;
  logic [DW-1:0] p_if_data, p_dm_data;
  bit            p_dm_wr;
  bit            a_rd;
  logic [SW-1:0] a_strb;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic [CW-1:0] m_cnt;
  bit            m_ifv, m_dmv;

  task automatic model_init();
    next_free = 0;
    lg_dm     = 1'b0;
    if_rsp_at = -1;
    dm_rsp_at = -1;
    acc_at    = -1;
    e_ifr     = '0;
    e_dmr     = '0;
    m_cnt     = '0;
    m_ifv     = 1'b0;
    m_dmv     = 1'b0;
  endtask

  task automatic model_step(int k);
    bit ev_if, ev_dm, dp, st, take_dm;
    ev_if = (if_rsp_at == k);
    ev_dm = (dm_rsp_at == k);
    if (ev_if) e_ifr = p_if_data;
    if (ev_dm && !p_dm_wr) e_dmr = p_dm_data;
    check("r_if_valid", bus.if_valid, ev_if);
    check("r_dm_valid", bus.dm_valid, ev_dm);
    check("r_if_rdata", bus.if_rdata, e_ifr);
    check("r_dm_rdata", bus.dm_rdata, e_dmr);
    check("r_mem_read", bus.mem_read, (acc_at == k) && a_rd);
    check("r_mem_write", bus.mem_write,
          (acc_at == k) ? a_strb : '0);
    if (acc_at == k) begin
      check("r_mem_addr", bus.mem_addr, a_addr);
      if (a_strb != '0) check("r_mem_wdata", bus.mem_wdata, a_wdata);
    end
    dp = bus.dm_read || (bus.dm_write != '0);
    st = (bus.if_req && !ev_if) || (dp && !ev_dm);
    check("r_cpu_stall", bus.cpu_stall, st);
    check("r_stall_cycles", bus.stall_cycles, m_cnt);
    if (st && m_cnt != CMAX) m_cnt = m_cnt + 1'b1;
    m_ifv = ev_if;
    m_dmv = ev_dm;
    if (k >= next_free && (bus.if_req || dp)) begin
      take_dm   = dp && (!bus.if_req || !lg_dm);
      acc_at    = k + 1;
      next_free = k + 3;
      if (take_dm) begin
        lg_dm     = 1'b1;
        dm_rsp_at = k + 2;
        a_addr    = bus.dm_addr;
        a_wdata   = bus.dm_wdata;
        a_strb    = bus.dm_write;
        a_rd      = (bus.dm_write == '0);
        p_dm_wr   = !a_rd;
        if (p_dm_wr)
          ref_mem[a_addr] = merge(ref_rd(a_addr), a_wdata, a_strb);
        else
          p_dm_data = ref_rd(a_addr);
      end else begin
        lg_dm     = 1'b0;
        if_rsp_at = k + 2;
        a_addr    = bus.if_addr;
        a_strb    = '0;
        a_rd      = 1'b1;
        p_if_data = ref_rd(a_addr);
      end
    end
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return AW'(32'h4000 + ($urandom_range(0, 15) << 2));
  endfunction

  task automatic new_dm();
    int t;
    t = $urandom_range(0, 3);
    bus.dm_addr  = rnd_addr();
    bus.dm_wdata = $urandom();
    bus.dm_read  = (t == 0 || t == 2);
    if (t == 0)      bus.dm_write = '0;
    else if (t == 3) bus.dm_write = '1;
    else             bus.dm_write = SW'($urandom_range(1, 15));
  endtask

  task automatic drive_rand(bit quiet);
    bit dp;
    if (bus.if_req) begin
      if (m_ifv) begin
        if (!quiet && $urandom_range(0, 1) == 1) bus.if_addr = rnd_addr();
        else bus.if_req = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        bus.if_addr = rnd_addr();
      end
    end else if (!quiet && $urandom_range(0, 2) == 0) begin
      bus.if_req  = 1'b1;
      bus.if_addr = rnd_addr();
    end
    dp = bus.dm_read || (bus.dm_write != '0);
    if (dp) begin
      if (m_dmv) begin
        if (!quiet && $urandom_range(0, 1) == 1) begin
          new_dm();
        end else begin
          bus.dm_read  = 1'b0;
          bus.dm_write = '0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        bus.dm_addr  = rnd_addr();
        bus.dm_wdata = $urandom();
      end
    end else if (!quiet && $urandom_range(0, 2) == 0) begin
      new_dm();
    end
  endtask

  initial begin
    sram[32'h100] = 32'h0050_0093;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_if_valid", bus.if_valid, 1'b0);
    check("rst_dm_valid", bus.dm_valid, 1'b0);
    check("rst_mem_read", bus.mem_read, 1'b0);
    check("rst_mem_write", bus.mem_write, 4'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_if_rdata", bus.if_rdata, 32'h0);
    check("rst_dm_rdata", bus.dm_rdata, 32'h0);
    check("rst_stall_cycles", bus.stall_cycles, 4'h0);
    check("rst_cpu_stall", bus.cpu_stall, 1'b0);

    // Fetch of 0x100; a late address change must be ignored
    cyc();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    @(negedge clk);
    check("t1_stall_n", bus.cpu_stall, 1'b1);
    check("t1_read_n", bus.mem_read, 1'b0);
    cyc();
    bus.if_addr = 32'h999;
    @(negedge clk);
    check("t1_mem_read", bus.mem_read, 1'b1);
    check("t1_mem_addr", bus.mem_addr, 32'h100);
    check("t1_stall_n1", bus.cpu_stall, 1'b1);
    cyc();
    @(negedge clk);
    check("t1_if_valid", bus.if_valid, 1'b1);
    check("t1_if_rdata", bus.if_rdata, 32'h0050_0093);
    check("t1_stall_n2", bus.cpu_stall, 1'b0);
    cyc();
    bus.if_req = 1'b0;
    @(negedge clk);
    check("t1_valid_pulse", bus.if_valid, 1'b0);
    check("t1_rdata_hold", bus.if_rdata, 32'h0050_0093);

    // Full-word write, then read back
    cyc();
    bus.dm_write = 4'hF;
    bus.dm_addr  = 32'h2000;
    bus.dm_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("t2_stall_n", bus.cpu_stall, 1'b1);
    cyc();
    @(negedge clk);
    check("t2_mem_write", bus.mem_write, 4'hF);
    check("t2_mem_read", bus.mem_read, 1'b0);
    check("t2_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    cyc();
    @(negedge clk);
    check("t2_dm_valid", bus.dm_valid, 1'b1);
    check("t2_dm_rdata_keep", bus.dm_rdata, 32'h0);
    cyc();
    bus.dm_write = '0;
    bus.dm_read  = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    check("t2_rd_valid", bus.dm_valid, 1'b1);
    check("t2_rd_data", bus.dm_rdata, 32'hDEAD_BEEF);
    cyc();
    bus.dm_read = 1'b0;

    // Both held from reset: DM first, then strict alternation
    do_reset();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    bus.dm_read = 1'b1;
    bus.dm_addr = 32'h2000;
    for (int j = 0; j < 12; j++) begin
      if (j > 0) cyc();
      @(negedge clk);
      check("t3_if_valid", bus.if_valid,
            (j % 3 == 2) && ((j / 3) % 2 == 1));
      check("t3_dm_valid", bus.dm_valid,
            (j % 3 == 2) && ((j / 3) % 2 == 0));
      if (j == 2) check("t3_dm_rdata", bus.dm_rdata, 32'hDEAD_BEEF);
      if (j == 5) check("t3_if_rdata", bus.if_rdata, 32'h0050_0093);
    end

    // Read and write together count as a write
    do_reset();
    bus.dm_read  = 1'b1;
    bus.dm_write = 4'b0011;
    bus.dm_addr  = 32'h3000;
    bus.dm_wdata = 32'h1122_3344;
    cyc();
    @(negedge clk);
    check("t4_mem_read", bus.mem_read, 1'b0);
    check("t4_mem_write", bus.mem_write, 4'b0011);
    cyc();
    @(negedge clk);
    check("t4_dm_valid", bus.dm_valid, 1'b1);
    check("t4_dm_rdata", bus.dm_rdata, 32'h0);

    // Reset during DM_ACC discards the access
    do_reset();
    bus.dm_read = 1'b1;
    bus.dm_addr = 32'h2000;
    cyc();
    @(negedge clk);
    check("t5_acc_read", bus.mem_read, 1'b1);
    rst         = 1'b1;
    bus.dm_read = 1'b0;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("t5_dm_valid", bus.dm_valid, 1'b0);
    check("t5_mem_read", bus.mem_read, 1'b0);
    check("t5_mem_addr", bus.mem_addr, 32'h0);
    check("t5_stall_cycles", bus.stall_cycles, 4'h0);
    check("t5_cpu_stall", bus.cpu_stall, 1'b0);
    cyc();
    @(negedge clk);
    check("t5_no_late_valid", bus.dm_valid, 1'b0);
    check("t5_dm_rdata", bus.dm_rdata, 32'h0);

    // Counter saturates rather than wrapping
    do_reset();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    bus.dm_read = 1'b1;
    bus.dm_addr = 32'h2000;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) cyc();
      @(negedge clk);
      check("t6_stall", bus.cpu_stall, 1'b1);
      check("t6_cnt", bus.stall_cycles, (k > 15) ? 15 : k);
    end

    // Random traffic against the reference model
    for (int s = 0; s < 4; s++) begin
      do_reset();
      model_init();
      for (int k = 0; k < 160; k++) begin
        if (k > 0) cyc();
        drive_rand(k >= 150);
        @(negedge clk);
        model_step(k);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
